// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control chain ID/EX..MEM/WB with load-use stall, branch flush and forwarding selects.
// Define PIPE_HAZARD_STATS_EN to add saturating stall_cnt/flush_cnt event counters.
module pipe_hazard_ctrl #(
  parameter int STAGES       = 3,
  parameter int REG_AW       = 5,
  parameter int CTRL_W       = 8,
  parameter int ZERO_REG     = 31,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        resetl,
  input  logic                        id_valid,
  input  logic [CTRL_W-1:0]           id_ctrl,
  input  logic [REG_AW-1:0]           id_rd,
  input  logic [REG_AW-1:0]           id_rs1,
  input  logic [REG_AW-1:0]           id_rs2,
  input  logic                        id_use_rs1,
  input  logic                        id_use_rs2,
  input  logic                        id_regwrite,
  input  logic                        id_memread,
  input  logic                        flush,
  output logic                        stall_front,
  output logic                        if_id_flush,
  output logic [STAGES-1:0]           stage_valid,
  output logic [STAGES*CTRL_W-1:0]    stage_ctrl,
  output logic [STAGES*REG_AW-1:0]    stage_rd,
  output logic [STAGES-1:0]           stage_regwrite,
  output logic [$clog2(STAGES)-1:0]   fwd_a_sel,
  output logic [$clog2(STAGES)-1:0]   fwd_b_sel
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [31:0]                 stall_cnt,
  output logic [31:0]                 flush_cnt
`endif
);

  localparam int SEL_W = $clog2(STAGES);
  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] rw_q;
  logic [REG_AW-1:0] rd_q   [STAGES];
  logic [CTRL_W-1:0] ctrl_q [STAGES];

  // Source operands and memread only matter while the instruction sits in ID/EX.
  logic [REG_AW-1:0] rs1_q, rs2_q;
  logic              use1_q, use2_q, mr_q;
  logic              hz;

  assign hz = v_q[0] & mr_q & rw_q[0] & (rd_q[0] != ZR) & id_valid &
              ((id_use_rs1 & (id_rs1 == rd_q[0])) | (id_use_rs2 & (id_rs2 == rd_q[0])));

  assign stall_front    = hz & ~flush;
  assign if_id_flush    = flush;
  assign stage_valid    = v_q;
  assign stage_regwrite = v_q & rw_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_flat
    assign stage_ctrl[g*CTRL_W +: CTRL_W] = ctrl_q[g];
    assign stage_rd[g*REG_AW +: REG_AW]   = rd_q[g];
  end

  // Descending scan so the youngest matching producer overrides older ones.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (v_q[0] && use1_q && rs1_q != ZR && v_q[k] && rw_q[k] && rd_q[k] == rs1_q)
        fwd_a_sel = SEL_W'(k);
      if (v_q[0] && use2_q && rs2_q != ZR && v_q[k] && rw_q[k] && rd_q[k] == rs2_q)
        fwd_b_sel = SEL_W'(k);
    end
  end

  always_ff @(negedge CLK) begin
    if (resetl) begin
      v_q    <= '0;
      rw_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      use1_q <= 1'b0;
      use2_q <= 1'b0;
      mr_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k]   <= '0;
        ctrl_q[k] <= '0;
      end
    end else begin
      // Older stages always advance; a flush bubbles the youngest FLUSH_STAGES.
      for (int k = STAGES - 1; k >= 1; k--) begin
        if (flush && k < FLUSH_STAGES) begin
          v_q[k]    <= 1'b0;
          rw_q[k]   <= 1'b0;
          rd_q[k]   <= '0;
          ctrl_q[k] <= '0;
        end else begin
          v_q[k]    <= v_q[k-1];
          rw_q[k]   <= rw_q[k-1];
          rd_q[k]   <= rd_q[k-1];
          ctrl_q[k] <= ctrl_q[k-1];
        end
      end
      if (hz || flush || !id_valid) begin
        v_q[0]    <= 1'b0;
        rw_q[0]   <= 1'b0;
        rd_q[0]   <= '0;
        ctrl_q[0] <= '0;
        rs1_q     <= '0;
        rs2_q     <= '0;
        use1_q    <= 1'b0;
        use2_q    <= 1'b0;
        mr_q      <= 1'b0;
      end else begin
        v_q[0]    <= 1'b1;
        rw_q[0]   <= id_regwrite;
        rd_q[0]   <= id_rd;
        ctrl_q[0] <= id_ctrl;
        rs1_q     <= id_rs1;
        rs2_q     <= id_rs2;
        use1_q    <= id_use_rs1;
        use2_q    <= id_use_rs2;
        mr_q      <= id_memread;
      end
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  always_ff @(negedge CLK) begin
    if (resetl) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_front && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != 32'hFFFF_FFFF)       flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
